taxi_pcie_vpd_store: RTL and testbench

VPD backing store: APB slave holding the VPD image served to the PCIe VPD capability, which is its APB master. At boot a word stream loads the read-only section (product info, VPD-R). The remaining space forms the host-writable VPD-W region. APB access is gated until the load completes and the store is zero-filled.

---
 rtl/taxi_pcie_vpd_pkg.sv | 15 +
 rtl/taxi_apb_if.sv | 34 +++
 rtl/taxi_pcie_vpd_ram.sv | 26 ++
 rtl/taxi_pcie_vpd_store.sv | 194 +++++++++++++++++++
 tb/tb_taxi_pcie_vpd_store.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/taxi_pcie_vpd_pkg.sv
// VPD store shared types: FSM state encoding
// and the APB byte-address width seen by the store.
package taxi_pcie_vpd_pkg;

  localparam int VPD_ADDR_W = 15;

  typedef enum logic [2:0] {
    VPD_ST_IDLE,
    VPD_ST_LOAD,
    VPD_ST_DRAIN,
    VPD_ST_FILL,
    VPD_ST_READY
  } vpd_state_t;

endpackage

// File: rtl/taxi_apb_if.sv
// APB bus bundle. mst drives request signals,
// slv drives pready/prdata/pslverr.
interface taxi_apb_if #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int STRB_W  = DATA_W/8,
  parameter int AUSER_W = 1,
  parameter int WUSER_W = 1
);
  logic [ADDR_W-1:0]  paddr;
  logic [2:0]         pprot;
  logic               psel;
  logic               penable;
  logic               pwrite;
  logic [DATA_W-1:0]  pwdata;
  logic [STRB_W-1:0]  pstrb;
  logic [AUSER_W-1:0] pauser;
  logic [WUSER_W-1:0] pwuser;
  logic               pready;
  logic [DATA_W-1:0]  prdata;
  logic               pslverr;

  modport mst (
    output paddr, pprot, psel, penable, pwrite,
    output pwdata, pstrb, pauser, pwuser,
    input  pready, prdata, pslverr
  );

  modport slv (
    input  paddr, pprot, psel, penable, pwrite,
    input  pwdata, pstrb, pauser, pwuser,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/taxi_pcie_vpd_ram.sv
// Single-port VPD word RAM, byte enables,
// registered read-first output, no reset.
module taxi_pcie_vpd_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we && be[b]) begin
        mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/taxi_pcie_vpd_store.sv
// VPD backing store: boot word stream loads the RO part,
// rest zero-filled; APB slave (s_apb) serves it once READY.
module taxi_pcie_vpd_store
  import taxi_pcie_vpd_pkg::*;
#(
  parameter int SIZE_BYTES = 1024,
  parameter int RO_BYTES   = 512
) (
  input  logic        clk,
  input  logic        rst_n,
  taxi_apb_if.slv     s_apb,
  input  logic [31:0] load_tdata,
  input  logic        load_tvalid,
  output logic        load_tready,
  input  logic        load_tlast,
  output logic        load_done,
  output logic        load_csum_ok,
  output logic        load_error
);

  localparam int SIZE_W = SIZE_BYTES/4;
  localparam int RO_W   = RO_BYTES/4;
  localparam int AW     = $clog2(SIZE_W);
  localparam logic [13:0] SIZE_WL = 14'(SIZE_W);
  localparam logic [13:0] RO_WL   = 14'(RO_W);

  if (s_apb.DATA_W != 32) begin : g_bad_w
    $fatal(0, "taxi_pcie_vpd_store: DATA_W must be 32");
  end

  vpd_state_t state, state_n;
  logic [13:0] wp, wp_n;
  logic [7:0]  sum, sum_n;
  logic        err, err_n;
  logic        ld_we;
  logic        acc;
  logic        tready_q;

  logic [13:0] idx;
  logic        in_range, writable;
  logic        apb_go, early;
  logic        pready_q, err_q, rd_ok_q, wr_ok_q;

  logic          ram_we;
  logic [3:0]    ram_be;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wd, ram_q;

  logic unused;
  assign unused = ^{s_apb.pprot, s_apb.pauser,
                    s_apb.pwuser, s_apb.paddr, idx, wp};

  assign acc = tready_q & load_tvalid;

  always_comb begin
    state_n = state;
    wp_n    = wp;
    sum_n   = sum;
    err_n   = err;
    ld_we   = 1'b0;
    unique case (state)
      VPD_ST_IDLE: begin
        state_n = VPD_ST_LOAD;
        wp_n    = '0;
        sum_n   = '0;
        err_n   = 1'b0;
      end
      VPD_ST_LOAD: begin
        if (RO_WL == 14'd0) begin
          state_n = VPD_ST_DRAIN;
          if (acc && load_tlast) begin
            err_n   = 1'b1;
            state_n = (wp == SIZE_WL) ? VPD_ST_READY
                                      : VPD_ST_FILL;
          end
        end else if (acc) begin
          ld_we = 1'b1;
          wp_n  = wp + 14'd1;
          sum_n = sum + load_tdata[7:0]
                + load_tdata[15:8]
                + load_tdata[23:16]
                + load_tdata[31:24];
          if (load_tlast) begin
            state_n = (wp_n == SIZE_WL) ? VPD_ST_READY
                                        : VPD_ST_FILL;
          end else if (wp == RO_WL - 14'd1) begin
            state_n = VPD_ST_DRAIN;
          end
        end
      end
      VPD_ST_DRAIN: begin
        if (acc && load_tlast) begin
          err_n   = 1'b1;
          state_n = (wp == SIZE_WL) ? VPD_ST_READY
                                    : VPD_ST_FILL;
        end
      end
      VPD_ST_FILL: begin
        ld_we = 1'b1;
        wp_n  = wp + 14'd1;
        if (wp == SIZE_WL - 14'd1) begin
          state_n = VPD_ST_READY;
        end
      end
      VPD_ST_READY: begin
      end
      default: state_n = VPD_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= VPD_ST_IDLE;
      wp       <= '0;
      sum      <= '0;
      err      <= 1'b0;
      tready_q <= 1'b0;
    end else begin
      state    <= state_n;
      wp       <= wp_n;
      sum      <= sum_n;
      err      <= err_n;
      tready_q <= (state_n == VPD_ST_LOAD) ||
                  (state_n == VPD_ST_DRAIN);
    end
  end

  assign load_tready  = tready_q;
  assign load_done    = (state == VPD_ST_READY);
  assign load_csum_ok = load_done & (sum == 8'd0);
  assign load_error   = load_done & err;

  assign idx      = {1'b0, s_apb.paddr[VPD_ADDR_W-1:2]};
  assign in_range = idx < SIZE_WL;
  assign writable = idx >= RO_WL;

  assign apb_go = (state == VPD_ST_READY) & s_apb.psel
                & s_apb.penable & ~pready_q;
  // before READY, answer at once with an error
  assign early  = rst_n & (state != VPD_ST_READY)
                & s_apb.psel & s_apb.penable;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pready_q <= 1'b0;
      err_q    <= 1'b0;
      rd_ok_q  <= 1'b0;
      wr_ok_q  <= 1'b0;
    end else if (pready_q) begin
      pready_q <= 1'b0;
      err_q    <= 1'b0;
      rd_ok_q  <= 1'b0;
      wr_ok_q  <= 1'b0;
    end else if (apb_go) begin
      pready_q <= 1'b1;
      err_q    <= ~in_range |
                  (s_apb.pwrite & ~writable);
      rd_ok_q  <= ~s_apb.pwrite & in_range;
      wr_ok_q  <= s_apb.pwrite & in_range & writable;
    end
  end

  assign s_apb.pready  = pready_q | early;
  assign s_apb.pslverr = (pready_q & err_q) | early;
  assign s_apb.prdata  = (pready_q & rd_ok_q) ? ram_q
                                              : 32'd0;

  // APB owns the RAM only in READY; load/fill never run there
  always_comb begin
    ram_we   = ld_we;
    ram_be   = 4'hF;
    ram_addr = wp[AW-1:0];
    ram_wd   = (state == VPD_ST_FILL) ? 32'd0 : load_tdata;
    if (state == VPD_ST_READY) begin
      ram_we   = pready_q & wr_ok_q;
      ram_be   = s_apb.pstrb;
      ram_addr = idx[AW-1:0];
      ram_wd   = s_apb.pwdata;
    end
  end

  taxi_pcie_vpd_ram #(
    .DEPTH (SIZE_W),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .be    (ram_be),
    .addr  (ram_addr),
    .wdata (ram_wd),
    .rdata (ram_q)
  );

endmodule

// File: tb/tb_taxi_pcie_vpd_store.sv
// Self-checking bench for taxi_pcie_vpd_store:
// image model + APB/flag compare against it.
module tb_taxi_pcie_vpd_store;

  localparam int SIZE_W = 256;
  localparam int RO_W   = 128;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  taxi_apb_if #(.DATA_W(32), .ADDR_W(16)) apb ();

  logic [31:0] load_tdata;
  logic        load_tvalid;
  logic        load_tready;
  logic        load_tlast;
  logic        load_done;
  logic        load_csum_ok;
  logic        load_error;

  taxi_pcie_vpd_store #(
    .SIZE_BYTES (1024),
    .RO_BYTES   (512)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_apb        (apb),
    .load_tdata   (load_tdata),
    .load_tvalid  (load_tvalid),
    .load_tready  (load_tready),
    .load_tlast   (load_tlast),
    .load_done    (load_done),
    .load_csum_ok (load_csum_ok),
    .load_error   (load_error)
  );

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(string nm,
                              logic [31:0] act,
                              logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endfunction

  // model: expected image, flags and cycles left to READY
  logic [31:0] mem_m [SIZE_W];
  logic [31:0] img [$];
  int  cd = -1;
  bit  exp_csum;
  bit  exp_err;

  always @(posedge clk) if (cd > 0) cd = cd - 1;

  always @(negedge clk) begin
    chk("done", 32'(load_done), 32'(cd == 0));
    if (cd == 0) begin
      chk("csum_ok", 32'(load_csum_ok), 32'(exp_csum));
      chk("error", 32'(load_error), 32'(exp_err));
      chk("tready_rdy", 32'(load_tready), 0);
    end
  end

  task automatic load_img(input int n, input bit rnd);
    int i = 0;
    int t = 0;
    int stored;
    bit acc;
    logic [7:0] s = 8'd0;
    while (i < n && t < 5000) begin
      load_tdata  = img[i];
      load_tlast  = (i == n-1);
      load_tvalid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      acc = load_tvalid && load_tready;
      @(posedge clk); #1;
      if (acc) i++;
      t++;
    end
    if (i < n) begin
      n_cmp++;
      n_bad++;
      $display("FAIL load_timeout: got %0d want %0d words", i, n);
    end
    load_tvalid = 1'b0;
    load_tlast  = 1'b0;
    stored = (n < RO_W) ? n : RO_W;
    for (int k = 0; k < SIZE_W; k++)
      mem_m[k] = (k < stored) ? img[k] : 32'd0;
    for (int k = 0; k < stored; k++)
      s = s + img[k][7:0] + img[k][15:8]
            + img[k][23:16] + img[k][31:24];
    exp_csum = (s == 8'd0);
    exp_err  = (n > RO_W);
    cd = SIZE_W - stored;
  endtask

  task automatic wait_done(output int cnt);
    cnt = 0;
    while (!load_done && cnt < 2000) begin
      @(posedge clk); #1;
      cnt++;
    end
  endtask

  task automatic apb_x(input logic [15:0] addr,
                       input bit wr,
                       input logic [31:0] wd,
                       input logic [3:0] st,
                       input string nm,
                       output logic [31:0] rd,
                       output logic er);
    logic [31:0] ed = 32'd0;
    bit ee = 1'b1;
    int ew = 0;
    int waits = 0;
    int idx = int'(addr[14:2]);
    if (cd == 0) begin
      ew = 1;
      if (idx >= SIZE_W) begin
        ee = 1'b1;
      end else if (wr) begin
        ee = (idx < RO_W);
        if (!ee)
          for (int b = 0; b < 4; b++)
            if (st[b]) mem_m[idx][8*b +: 8] = wd[8*b +: 8];
      end else begin
        ee = 1'b0;
        ed = mem_m[idx];
      end
    end
    apb.psel    = 1'b1;
    apb.penable = 1'b0;
    apb.paddr   = addr;
    apb.pwrite  = wr;
    apb.pwdata  = wd;
    apb.pstrb   = st;
    @(posedge clk); #1;
    apb.penable = 1'b1;
    @(negedge clk);
    while (!apb.pready && waits < 20) begin
      waits++;
      @(negedge clk);
    end
    rd = apb.prdata;
    er = apb.pslverr;
    chk({nm, "_data"}, apb.prdata, ed);
    chk({nm, "_err"}, 32'(apb.pslverr), 32'(ee));
    chk({nm, "_waits"}, waits, ew);
    @(posedge clk); #1;
    apb.psel    = 1'b0;
    apb.penable = 1'b0;
  endtask

  task automatic do_reset();
    cd    = -1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  logic [31:0] rd;
  logic        er;
  int          cnt;

  initial begin
    load_tdata  = '0;
    load_tvalid = 1'b0;
    load_tlast  = 1'b0;
    apb.psel    = 1'b0;
    apb.penable = 1'b0;
    apb.paddr   = '0;
    apb.pwrite  = 1'b0;
    apb.pwdata  = '0;
    apb.pstrb   = '0;
    apb.pprot   = '0;
    apb.pauser  = '0;
    apb.pwuser  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tready", 32'(load_tready), 0);
    chk("rst_done", 32'(load_done), 0);
    chk("rst_csum", 32'(load_csum_ok), 0);
    chk("rst_err", 32'(load_error), 0);
    chk("rst_pready", 32'(apb.pready), 0);
    chk("rst_pslverr", 32'(apb.pslverr), 0);
    chk("rst_prdata", apb.prdata, 0);
    rst_n = 1'b1;

    // 4-word image, byte sum 1..12 + 0xB2 = 256
    img = '{32'h04030201, 32'h08070605,
            32'h0C0B0A09, 32'hB2000000};
    load_img(4, 1'b0);
    wait_done(cnt);
    chk("lat4", cnt, 252);
    chk("lit_csum4", 32'(load_csum_ok), 1);
    chk("lit_err4", 32'(load_error), 0);
    apb_x(16'h000C, 0, 0, 0, "rd0c", rd, er);
    chk("lit_0c", rd, 32'hB2000000);
    apb_x(16'h0010, 0, 0, 0, "rd10", rd, er);
    chk("lit_10", rd, 32'h0);

    // 130 words into 128-word RO region, APB poke mid-load
    do_reset();
    img.delete();
    for (int k = 0; k < 130; k++) img.push_back(32'h10000000 + k);
    fork
      load_img(130, 1'b0);
      begin
        repeat (10) @(posedge clk);
        #1;
        apb_x(16'h0000, 0, 0, 0, "ldrd", rd, er);
        chk("lit_ldrd_err", 32'(er), 1);
      end
    join
    wait_done(cnt);
    chk("lat130", cnt, 128);
    chk("lit_err130", 32'(load_error), 1);
    apb_x(16'h01FC, 0, 0, 0, "rd1fc", rd, er);
    chk("lit_1fc", rd, 32'h1000007F);
    apb_x(16'h0200, 0, 0, 0, "rd200a", rd, er);
    chk("lit_200a", rd, 32'h0);
    apb_x(16'h0200, 1, 32'hDEADBEEF, 4'b0011, "wr200", rd, er);
    chk("lit_wr200_err", 32'(er), 0);
    apb_x(16'h0200, 0, 0, 0, "rd200b", rd, er);
    chk("lit_200b", rd, 32'h0000BEEF);
    apb_x(16'h0100, 1, 32'hFFFFFFFF, 4'hF, "wr100", rd, er);
    chk("lit_wr100_err", 32'(er), 1);
    apb_x(16'h0100, 0, 0, 0, "rd100", rd, er);
    chk("lit_100", rd, 32'h10000040);
    apb_x(16'h0400, 0, 0, 0, "rd400", rd, er);
    chk("lit_400_err", 32'(er), 1);
    apb_x(16'h0400, 1, 32'h12345678, 4'hF, "wr400", rd, er);
    apb_x(16'h03FC, 1, 32'hCAFEF00D, 4'b1100, "wr3fc", rd, er);
    apb_x(16'h03FC, 0, 0, 0, "rd3fc", rd, er);
    chk("lit_3fc", rd, 32'hCAFE0000);

    // reset in FILL, then reload a bad-checksum image
    do_reset();
    img.delete();
    for (int k = 0; k < 10; k++) img.push_back(32'h11111111 * k);
    load_img(10, 1'b0);
    repeat (50) @(posedge clk);
    #1;
    cd    = -1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("lit_rst_fill_done", 32'(load_done), 0);
    @(posedge clk); #1;
    chk("lit_rst_fill_tready", 32'(load_tready), 0);
    rst_n = 1'b1;
    img.delete();
    for (int k = 0; k < 8; k++) img.push_back(32'h00000001 + (k << 8));
    load_img(8, 1'b1);
    wait_done(cnt);
    chk("lat8", cnt, 248);
    chk("lit_csum_bad", 32'(load_csum_ok), 0);
    fork
      begin
        repeat (60) begin
          @(posedge clk); #1;
          load_tvalid = 1'($urandom_range(0, 1));
          load_tdata  = $urandom;
        end
      end
      begin
        for (int k = 0; k < 10; k++)
          apb_x(16'(k*4), 0, 0, 0, "b2b", rd, er);
        apb_x(16'h0204, 1, 32'hA5A5A5A5, 4'hF, "b2bw", rd, er);
        apb_x(16'h0204, 0, 0, 0, "b2br", rd, er);
        chk("lit_204", rd, 32'hA5A5A5A5);
      end
    join
    load_tvalid = 1'b0;
    apb_x(16'h001C, 0, 0, 0, "rd1c", rd, er);
    chk("lit_1c", rd, 32'h00000701);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
